// File: rtl/strided_vector_constructor.sv
// Gathers strided elements from a synchronous-read RAM and packs them into
// VECTOR_DIMENSION-wide vectors, handing each off through a valid/ready port.
module strided_vector_constructor #(
  parameter int ELEMENT_WIDTH    = 24,
  parameter int ADDR_WIDTH       = 8,
  parameter int VECTOR_DIMENSION = 3,
  parameter int COUNT_WIDTH      = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDR_WIDTH-1:0]    base_addr,
  input  logic [ADDR_WIDTH-1:0]    stride,
  input  logic [COUNT_WIDTH-1:0]   expected_elements,
  input  logic [ELEMENT_WIDTH-1:0] element_in,
  output logic [ADDR_WIDTH-1:0]    addr,
  output logic [ELEMENT_WIDTH-1:0] vector [0:VECTOR_DIMENSION-1],
  output logic                     vector_valid,
  input  logic                     vector_ready,
  output logic                     vector_last,
  output logic [COUNT_WIDTH-1:0]   elements_received,
  output logic                     busy,
  output logic                     done
);

  localparam int LANE_W = (VECTOR_DIMENSION > 1) ? $clog2(VECTOR_DIMENSION) : 1;
  localparam int ISS_W  = $clog2(VECTOR_DIMENSION + 1);
  localparam logic [ISS_W-1:0]  ISS_MAX  = ISS_W'(VECTOR_DIMENSION);
  localparam logic [LANE_W-1:0] LANE_MAX = LANE_W'(VECTOR_DIMENSION - 1);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DONE} state_t;

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  stride_q;
  logic [COUNT_WIDTH-1:0] expected_q;
  logic [COUNT_WIDTH-1:0] issued_total;
  logic [ISS_W-1:0]       issue_cnt;
  logic [LANE_W-1:0]      lane;
  logic                   rd_vld_p0;
  logic                   rd_vld_p1;
  logic                   issue_more;
  logic                   cap_final;
  logic                   cap_full;
  logic [COUNT_WIDTH-1:0] received_next;

  assign issue_more    = (issue_cnt != ISS_MAX) && (issued_total != expected_q);
  assign received_next = elements_received + 1'b1;
  assign cap_final     = (received_next == expected_q);
  assign cap_full      = (lane == LANE_MAX);

  // rd_vld_p0: an address is on the RAM bus; rd_vld_p1: its data is on element_in
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      stride_q          <= '0;
      expected_q        <= '0;
      issued_total      <= '0;
      issue_cnt         <= '0;
      lane              <= '0;
      rd_vld_p0         <= 1'b0;
      rd_vld_p1         <= 1'b0;
      addr              <= '0;
      vector_valid      <= 1'b0;
      vector_last       <= 1'b0;
      elements_received <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      for (int i = 0; i < VECTOR_DIMENSION; i++) vector[i] <= '0;
    end else begin
      rd_vld_p1 <= rd_vld_p0;
      rd_vld_p0 <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            stride_q          <= stride;
            expected_q        <= expected_elements;
            elements_received <= '0;
            lane              <= '0;
            vector_last       <= 1'b0;
            for (int i = 0; i < VECTOR_DIMENSION; i++) vector[i] <= '0;
            if (expected_elements == '0) begin
              state        <= DONE;
              busy         <= 1'b0;
              done         <= 1'b1;
              issued_total <= '0;
              issue_cnt    <= '0;
            end else begin
              state        <= FETCH;
              busy         <= 1'b1;
              done         <= 1'b0;
              addr         <= base_addr;
              rd_vld_p0    <= 1'b1;
              issue_cnt    <= ISS_W'(1);
              issued_total <= COUNT_WIDTH'(1);
            end
          end
        end
        FETCH: begin
          if (issue_more) begin
            addr         <= addr + stride_q;
            rd_vld_p0    <= 1'b1;
            issue_cnt    <= issue_cnt + 1'b1;
            issued_total <= issued_total + 1'b1;
          end
          if (rd_vld_p1) begin
            vector[lane]      <= element_in;
            elements_received <= received_next;
            if (cap_full || cap_final) begin
              state        <= HOLD;
              vector_valid <= 1'b1;
              vector_last  <= cap_final;
              lane         <= '0;
            end else begin
              lane <= lane + 1'b1;
            end
          end
        end
        HOLD: begin
          if (vector_ready) begin
            vector_valid <= 1'b0;
            vector_last  <= 1'b0;
            if (elements_received == expected_q) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              // Next vector starts clean so a short final vector has zero upper lanes
              state        <= FETCH;
              addr         <= addr + stride_q;
              rd_vld_p0    <= 1'b1;
              issue_cnt    <= ISS_W'(1);
              issued_total <= issued_total + 1'b1;
              for (int i = 0; i < VECTOR_DIMENSION; i++) vector[i] <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_strided_vector_constructor.sv
// Scoreboard bench for strided_vector_constructor: a list-level model predicts
// every vector of a job; a monitor compares each accepted vector.
`timescale 1ns/1ps
module tb_strided_vector_constructor;

  localparam int EW = 24;
  localparam int AW = 3;
  localparam int D  = 3;
  localparam int CW = 16;
  localparam int AMASK = (1 << AW) - 1;

  typedef struct packed {
    logic [D*EW-1:0] data;
    logic            last;
    logic [CW-1:0]   rcv;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] stride;
  logic [CW-1:0] expected_elements;
  logic [EW-1:0] element_in;
  logic [AW-1:0] addr;
  logic [EW-1:0] vec [0:D-1];
  logic          vector_valid;
  logic          vector_ready;
  logic          vector_last;
  logic [CW-1:0] elements_received;
  logic          busy;
  logic          done;

  logic [EW-1:0] ram [0:(1<<AW)-1];
  exp_t          sb [$];
  int            n_checks = 0;
  int            n_fail   = 0;

  strided_vector_constructor #(
    .ELEMENT_WIDTH(EW), .ADDR_WIDTH(AW), .VECTOR_DIMENSION(D), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .stride(stride),
    .expected_elements(expected_elements), .element_in(element_in), .addr(addr),
    .vector(vec), .vector_valid(vector_valid), .vector_ready(vector_ready),
    .vector_last(vector_last), .elements_received(elements_received),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM: data for an address appears one cycle later
  always @(posedge clk) element_in <= ram[addr];

  function automatic logic [D*EW-1:0] packed_vec();
    logic [D*EW-1:0] p;
    for (int l = 0; l < D; l++) p[l*EW +: EW] = vec[l];
    return p;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: element k of a job is RAM[(base + k*stride) mod 2^AW];
  // elements are grouped D at a time, the last group zero-padded.
  task automatic push_job(input int b, input int s, input int cnt);
    int   nvec;
    exp_t e;
    nvec = (cnt + D - 1) / D;
    for (int v = 0; v < nvec; v++) begin
      e.data = '0;
      for (int l = 0; l < D; l++) begin
        int k;
        k = v * D + l;
        if (k < cnt) e.data[l*EW +: EW] = ram[(b + k * s) & AMASK];
      end
      e.last = (v == nvec - 1);
      e.rcv  = CW'(((v + 1) * D < cnt) ? (v + 1) * D : cnt);
      sb.push_back(e);
    end
  endtask

  // Monitor: a handshake completes on the next rising edge
  always @(negedge clk) begin
    if (vector_valid && vector_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_vector: got %0h expected none at %0t", packed_vec(), $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("vector", packed_vec(), e.data);
        check("vector_last", vector_last, e.last);
        check("elements_received", elements_received, e.rcv);
      end
    end
  end

  task automatic run_job(input int b, input int s, input int cnt,
                         input bit rr, input bit stall, input bit poke);
    int cyc;
    bit first;
    int nfirst;
    logic [D*EW-1:0] snap;
    logic [AW-1:0]   snap_addr;
    push_job(b, s, cnt);
    base_addr = AW'(b);
    stride = AW'(s);
    expected_elements = CW'(cnt);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (cnt == 0) begin
      check("zero_done", done, 1);
      check("zero_busy", busy, 0);
    end else begin
      check("addr_first", addr, b & AMASK);
      check("busy_fetch", busy, 1);
    end
    cyc = 0;
    first = 1'b1;
    nfirst = (cnt < D) ? cnt : D;
    while (!done && cyc < 2000) begin
      vector_ready = (stall && first) ? 1'b0 : (rr ? 1'($urandom_range(0, 1)) : 1'b1);
      if (poke && cyc == 2) begin
        start = 1'b1;
        base_addr = 3'd5;
        stride = 3'd2;
        expected_elements = 16'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      if (cyc < nfirst) check("addr_seq", addr, (b + cyc * s) & AMASK);
      if (vector_valid && first) begin
        first = 1'b0;
        check("first_valid_latency", cyc, nfirst + 1);
        if (stall) begin
          snap = packed_vec();
          snap_addr = addr;
          for (int i = 0; i < 5; i++) begin
            vector_ready = 1'b0;
            @(posedge clk); #1;
            cyc++;
            check("stall_valid", vector_valid, 1);
            check("stall_vector", packed_vec(), snap);
            check("stall_addr", addr, snap_addr);
          end
        end
      end
    end
    start = 1'b0;
    vector_ready = 1'b0;
    if (cyc >= 2000) begin
      n_checks++;
      n_fail++;
      $display("FAIL job_timeout: got busy=%0b expected done within 2000 cycles", busy);
    end
    check("done_end", done, 1);
    check("busy_end", busy, 0);
    check("received_end", elements_received, cnt);
    check("scoreboard_empty", sb.size(), 0);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    base_addr = '0;
    stride = '0;
    expected_elements = '0;
    vector_ready = 1'b0;
    ram[0] = 24'h00AA00; ram[1] = 24'h01B480; ram[2] = 24'h005916; ram[3] = 24'h0015F0;
    ram[4] = 24'h45557E; ram[5] = 24'h020000; ram[6] = 24'h0C0FFE; ram[7] = 24'h777777;

    repeat (2) @(posedge clk);
    #1;
    check("rst_addr", addr, 0);
    check("rst_vector", packed_vec(), 0);
    check("rst_valid", vector_valid, 0);
    check("rst_last", vector_last, 0);
    check("rst_received", elements_received, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    run_job(0, 1, 6, 1'b0, 1'b0, 1'b0);   // two full vectors
    run_job(0, 1, 4, 1'b0, 1'b0, 1'b0);   // short final vector
    run_job(6, 3, 3, 1'b0, 1'b0, 1'b0);   // address wrap: 6,1,4
    run_job(0, 1, 6, 1'b0, 1'b1, 1'b0);   // ready held low after first vector
    run_job(0, 1, 0, 1'b0, 1'b0, 1'b0);   // empty job
    run_job(0, 1, 6, 1'b0, 1'b0, 1'b1);   // start while busy is ignored
    run_job(2, 0, 5, 1'b1, 1'b0, 1'b0);   // stride 0 repeats base

    // Reset in the middle of a fetch discards the job
    base_addr = 3'd0;
    stride = 3'd1;
    expected_elements = 16'd6;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("midrst_addr", addr, 0);
    check("midrst_vector", packed_vec(), 0);
    check("midrst_valid", vector_valid, 0);
    check("midrst_last", vector_last, 0);
    check("midrst_received", elements_received, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    @(posedge clk); #1;
    check("midrst_held_valid", vector_valid, 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("postrst_idle_busy", busy, 0);
    run_job(0, 1, 3, 1'b0, 1'b0, 1'b0);

    for (int j = 0; j < 40; j++) begin
      for (int a = 0; a < (1 << AW); a++) ram[a] = EW'($urandom);
      run_job(int'($urandom_range(0, AMASK)), int'($urandom_range(0, AMASK)),
              int'($urandom_range(0, 10)), 1'b1, 1'b0, 1'b0);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/strided_vector_constructor.md
STRIDED_VECTOR_CONSTRUCTOR -- requirements
Module: strided_vector_constructor

Interface
REQ-001 SHALL have parameter ELEMENT_WIDTH, default 24, bits per vector element.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, RAM address width.
REQ-003 SHALL have parameter VECTOR_DIMENSION, default 3, elements per output vector (>=1).
REQ-004 SHALL have parameter COUNT_WIDTH, default 16, width of element counts.
REQ-005 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  input  1  begin a job; sampled only in IDLE or DONE.
REQ-008 SHALL have port base_addr  input  ADDR_WIDTH  address of first element.
REQ-009 SHALL have port stride  input  ADDR_WIDTH  address increment between elements.
REQ-010 SHALL have port expected_elements  input  COUNT_WIDTH  total elements in the job.
REQ-011 SHALL have port element_in  input  ELEMENT_WIDTH  RAM read data, valid 1 cycle after addr.
REQ-012 SHALL have port addr  output  ADDR_WIDTH  RAM read address.
REQ-013 SHALL have port vector  output  ELEMENT_WIDTH x [0:VECTOR_DIMENSION-1]  assembled vector.
REQ-014 SHALL have port vector_valid  output  1  vector holds a complete vector.
REQ-015 SHALL have port vector_ready  input  1  downstream accepts vector when high with vector_valid.
REQ-016 SHALL have port vector_last  output  1  current vector is the job's final vector.
REQ-017 SHALL have port elements_received  output  COUNT_WIDTH  elements captured this job.
REQ-018 SHALL have port busy  output  1  high in FETCH or HOLD.
REQ-019 SHALL have port done  output  1  high in DONE.

Function
REQ-020 SHALL implement states IDLE, FETCH, HOLD, DONE.
REQ-021 In IDLE/DONE, start=1 SHALL latch base_addr, stride, expected_elements, clear elements_received and vector, and enter FETCH; if expected_elements=0, enter DONE instead.
REQ-022 start SHALL be ignored in FETCH and HOLD.
REQ-023 In FETCH, addr SHALL issue one address per cycle: base_addr + k*stride for element k, modulo 2^ADDR_WIDTH (wrap silently; stride 0 repeats base_addr).
REQ-024 element_in for element k SHALL be written to vector[k mod VECTOR_DIMENSION] one cycle after its address is issued, and elements_received SHALL increment on each capture.
REQ-025 FETCH SHALL issue no more than the elements remaining in the current vector.
REQ-026 When the last element of a vector is captured, the FSM SHALL enter HOLD with vector_valid=1 on the same edge; first vector_valid SHALL occur VECTOR_DIMENSION+1 rising edges after the edge sampling start.
REQ-027 In HOLD, vector and vector_last SHALL stay stable and addr SHALL stay at its last issued value until vector_valid and vector_ready are both high.
REQ-028 On handshake, vector_valid SHALL drop next edge; the FSM SHALL enter DONE if elements_received = expected_elements, else FETCH.
REQ-029 If expected_elements is not a multiple of VECTOR_DIMENSION, the final vector SHALL carry the remaining elements in the low lanes, zero in unused lanes, and SHALL enter HOLD after the last capture.
REQ-030 vector_last SHALL be high with vector_valid exactly for the final vector.
REQ-031 vector_ready while vector_valid=0 SHALL have no effect.
REQ-032 done SHALL remain high until a new start is accepted; start in DONE SHALL behave as in IDLE.
REQ-033 elements_received SHALL hold its final value in DONE.

Reset
REQ-034 reset=0 SHALL, asynchronously and in any state, force IDLE with addr=0, vector lanes=0, vector_valid=0, vector_last=0, elements_received=0, busy=0, done=0.
REQ-035 A job interrupted by reset SHALL be discarded; no vector_valid SHALL appear until a new start after reset=1.

Verification
REQ-036 RAM[0..5]={AA00,1B480,5916,15F0,45557E,20000}, D=3, base 0, stride 1, count 6, ready=1 -> vectors {AA00,1B480,5916} then {15F0,45557E,20000}, vector_last on second, done, elements_received=6.
REQ-037 Same RAM, count 4 -> second vector {15F0,0,0}, vector_last=1, elements_received=4.
REQ-038 ADDR_WIDTH=3, base 6, stride 3, count 3 -> addr sequence 6,1,4 (wrap); vector={RAM[6],RAM[1],RAM[4]}.
REQ-039 ready held 0 for 5 cycles after first vector_valid -> vector and addr stable, no new addr issued; accept then proceeds.
REQ-040 reset=0 in mid-FETCH, then start with count 3 -> all outputs zero immediately; new job yields a correct vector 4 edges after start.
REQ-041 count 0 -> DONE one edge after start, vector_valid never asserted; start while busy ignored.
